counter_priority_ctrl: RTL and testbench
========================================

// Module: counter_priority_ctrl
// PURPOSE
//  Schedules counter-increment cycles between instruction memory cycles.
//  Latches PINC/MINC request pulses from up to NREQ counter cells.
//  At each memory-cycle boundary (T12 strobe from timer), steals the next
//  memory cycle for one pending cell, or releases it to the sequencer.
//  Sits between the timer/scaler/IO request sources and sq_register, which
//  holds off NISQ while CTR_ACT is high.
// PARAMETERS
//  NREQ    8  number of counter cells (request channels), 2..16
//  MAXRUN  4  max consecutive counter cycles before one cycle is forced to the sequencer
// PORTS
//  CLOCK     in   1             system clock
//  SIM_RST   in   1             reset, synchronous, active-high
//  GOJAM     in   1             hardware restart; synchronous clear, same effect as SIM_RST
//  T12       in   1             one-CLOCK strobe marking end of memory cycle
//  INHINC    in   1             inhibit new counter grants (sampled at T12 edge)
//  PLS       in   NREQ          per-cell plus request pulses
//  MNS       in   NREQ          per-cell minus request pulses
//  CTROR     out  1             any request pending (OR of pending regs)
//  CTR_ACT   out  1             current memory cycle is a counter cycle
//  CTR_GNT   out  NREQ          one-hot granted cell, zero when CTR_ACT=0
//  CTR_ADDR  out  $clog2(NREQ)  index of granted cell, 0 when idle
//  CTR_PINC  out  1             granted operation is +1
//  CTR_MINC  out  1             granted operation is -1
//  CTR_LOST  out  1             sticky: a request hit an already-pending same-sign bit
// BEHAVIOUR
//  - All state is registered on the CLOCK posedge.
//  - SIM_RST or GOJAM: pending regs=0, CTR_ACT=0, CTR_GNT=0, CTR_ADDR=0,
//    PINC=MINC=0, CTR_LOST=0, run count=0, state IDLE.
//  - Pending: pp[i] |= PLS[i], pm[i] |= MNS[i] every edge.
//    If pp[i] and pm[i] would both be set (pending or same-edge arrival), both clear
//    (net zero); no grant for that cell.
//  - A request to an already-set same-sign bit is dropped; CTR_LOST is set.
//  - Eligibility at a T12 edge uses pending values registered before that edge.
//    Same-edge arrivals latch but become eligible at the next T12 only.
//  - FSM states: IDLE, ACTIVE. Outputs change only on T12 edges, except reset/GOJAM.
//  - At T12, a grant is issued if: some cell is eligible, INHINC=0, and run<MAXRUN.
//    On grant: state=ACTIVE, selected cell's pending bit is cleared,
//    CTR_GNT/ADDR/PINC|MINC are held for the whole following cycle (until next T12),
//    and run is incremented.
//  - Otherwise at T12: state=IDLE, outputs cleared, run=0.
//  - A new request on the cell being cleared, on the same edge, stays pending.
//  - Latency: a pulse at least one edge before T12 is granted at that T12.
//    The counter cycle is therefore the next memory cycle.
//  - Starvation guard: after MAXRUN back-to-back grants, the next T12 forces IDLE
//    for one memory cycle even with requests pending. run then resets to 0.
//  - Exactly one of PINC/MINC is high iff CTR_ACT=1. CTROR is combinational from
//    pending regs.
//  - T12 is ignored on the edge where SIM_RST or GOJAM is high.
// CONFIGURATION
//  CTR_ROUND_ROBIN_EN undefined: fixed priority; lowest index wins (cell 0 highest).
//  CTR_ROUND_ROBIN_EN defined: rotating priority; search starts at last granted
//    index+1, mod NREQ. The pointer resets to 0 and advances only on a grant.
// TESTING
//  1. PLS[3] pulse, then T12 -> CTR_ACT=1, ADDR=3, GNT=8'h08, PINC=1 for one cycle;
//     next T12 -> all 0.
//  2. PLS[5] and MNS[5] both pending, then T12 -> no grant, CTROR=0, CTR_ACT=0.
//  3. PLS[1], PLS[6], MNS[2] pending -> fixed priority grants 1, 2 (MINC), 6
//     on successive T12s.
//  4. MAXRUN=4, NREQ=8, all PLS pending -> 4 grants (0..3), one idle cycle,
//     then grants 4..7.
//  5. GOJAM during ACTIVE with 3 pending -> next edge all outputs 0, CTROR=0;
//     following T12 -> no grant.
//  6. PLS[2] twice before T12 -> CTR_LOST=1, one grant; with CTR_ROUND_ROBIN_EN,
//     after grant 2, pending {0,3} grants 3 then 0.

Source files
------------

// File: rtl/counter_priority_ctrl_if.sv
// counter_priority_ctrl_if
// Purpose: groups the request, strobe and grant signals exchanged between the
// counter request sources (timer/scaler/IO cells) and the counter priority
// controller. The controller connects through the slave modport; the request
// side (or a testbench) uses the master modport.
// Signals:
//   gojam   hardware restart, synchronous clear (master -> slave)
//   t12     one-clock strobe marking the end of a memory cycle
//   inhinc  inhibit new counter grants, sampled on the t12 edge
//   pls     per-cell plus request pulses, NREQ wide
//   mns     per-cell minus request pulses, NREQ wide
//   ctrOr   any request pending (slave -> master)
//   ctrAct  current memory cycle is a counter cycle
//   ctrGnt  one-hot granted cell, zero when idle
//   ctrAddr index of granted cell, zero when idle
//   ctrPinc granted operation is +1
//   ctrMinc granted operation is -1
//   ctrLost sticky flag: a request hit an already-pending same-sign bit
interface counter_priority_ctrl_if #(
  parameter int NREQ = 8
);
  localparam int AW = $clog2(NREQ);

  logic            gojam;
  logic            t12;
  logic            inhinc;
  logic [NREQ-1:0] pls;
  logic [NREQ-1:0] mns;
  logic            ctrOr;
  logic            ctrAct;
  logic [NREQ-1:0] ctrGnt;
  logic [AW-1:0]   ctrAddr;
  logic            ctrPinc;
  logic            ctrMinc;
  logic            ctrLost;

  // Request side: drives pulses and strobes, observes the grant.
  modport master (
    output gojam, t12, inhinc, pls, mns,
    input  ctrOr, ctrAct, ctrGnt, ctrAddr, ctrPinc, ctrMinc, ctrLost
  );

  // Controller side.
  modport slave (
    input  gojam, t12, inhinc, pls, mns,
    output ctrOr, ctrAct, ctrGnt, ctrAddr, ctrPinc, ctrMinc, ctrLost
  );
endinterface

// File: rtl/counter_priority_ctrl.sv
// counter_priority_ctrl
// Purpose: schedules counter-increment cycles between instruction memory
// cycles. PLS/MNS pulses from up to NREQ counter cells are latched into
// pending registers; at each memory-cycle boundary (t12 strobe) the next
// memory cycle is either stolen for one pending cell or released to the
// sequencer. After MAXRUN back-to-back counter cycles one cycle is forced
// back to the sequencer so it can never be starved.
// Ports:
//   clock_i   system clock
//   simRst_i  synchronous active-high reset
//   bus_io    counter_priority_ctrl_if.slave (gojam, t12, inhinc, pls, mns in;
//             ctrOr, ctrAct, ctrGnt, ctrAddr, ctrPinc, ctrMinc, ctrLost out)
// Configuration macro:
//   CTR_ROUND_ROBIN_EN  undefined: fixed priority, cell 0 highest.
//                       defined: rotating priority, search starts one past
//                       the last granted cell.
module counter_priority_ctrl #(
  parameter int NREQ   = 8,
  parameter int MAXRUN = 4
) (
  input  logic                  clock_i,
  input  logic                  simRst_i,
  counter_priority_ctrl_if.slave bus_io
);

  localparam int AW = $clog2(NREQ);
  localparam int RW = $clog2(MAXRUN + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pendPlus_q, pendPlus_d;
  logic [NREQ-1:0] pendMinus_q, pendMinus_d;
  logic [RW-1:0]   run_q, run_d;
  logic [AW-1:0]   gntIdx_q, gntIdx_d;
  logic            gntPlus_q, gntPlus_d;
  logic            lost_q, lost_d;

  logic            clearNow;
  logic [NREQ-1:0] eligible;
  logic [AW-1:0]   searchStart;
  logic            selFound;
  logic [AW-1:0]   selIdx;
  logic            grantNow;
  logic [NREQ-1:0] selOneHot;
  logic [NREQ-1:0] clrPlus, clrMinus;
  logic [NREQ-1:0] mergedPlus, mergedMinus, cancel;
  logic            lostNow;
  int              cand;
  logic [AW-1:0]   candIdx;

  // GOJAM behaves exactly like the reset, and both override any t12 strobe.
  assign clearNow = simRst_i | bus_io.gojam;

  // A cell never holds both signs at once, so either bit marks it eligible.
  // Only values registered before this edge take part in the decision.
  assign eligible = pendPlus_q | pendMinus_q;

`ifdef CTR_ROUND_ROBIN_EN
  localparam logic [AW-1:0] LAST_IDX = AW'(NREQ - 1);

  logic [AW-1:0] ptr_q, ptr_d;

  // The rotating pointer moves to one past the granted cell, wrapping at NREQ,
  // and only on an actual grant.
  always_comb begin
    ptr_d = ptr_q;
    if (grantNow) begin
      ptr_d = (selIdx == LAST_IDX) ? '0 : selIdx + AW'(1);
    end
  end

  // Pointer register, cleared by reset or GOJAM.
  always_ff @(posedge clock_i) begin
    if (clearNow) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign searchStart = ptr_q;
`else
  assign searchStart = '0;
`endif

  // Walk the cells starting at searchStart (wrapping) and pick the first
  // eligible one. With a zero start this is plain lowest-index priority.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(searchStart) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      candIdx = AW'(cand);
      if (!selFound && eligible[candIdx]) begin
        selFound = 1'b1;
        selIdx   = candIdx;
      end
    end
  end

  // A grant needs a strobe, a candidate, no inhibit and room left in the run.
  assign grantNow  = bus_io.t12 & selFound & ~bus_io.inhinc & (run_q < RW'(MAXRUN));
  assign selOneHot = {{(NREQ-1){1'b0}}, 1'b1} << selIdx;
  assign clrPlus   = (grantNow &  pendPlus_q[selIdx]) ? selOneHot : '0;
  assign clrMinus  = (grantNow & ~pendPlus_q[selIdx]) ? selOneHot : '0;

  // Pending update: the granted bit is consumed first, so a fresh pulse on the
  // same cell and edge simply re-arms it. A pulse onto a bit that is still
  // set is dropped and flagged. Opposite signs meeting on a cell cancel out.
  always_comb begin
    mergedPlus  = (pendPlus_q  & ~clrPlus)  | bus_io.pls;
    mergedMinus = (pendMinus_q & ~clrMinus) | bus_io.mns;
    cancel      = mergedPlus & mergedMinus;
    pendPlus_d  = mergedPlus  & ~cancel;
    pendMinus_d = mergedMinus & ~cancel;
    lostNow     = |((pendPlus_q  & ~clrPlus  & bus_io.pls) |
                    (pendMinus_q & ~clrMinus & bus_io.mns));
    lost_d      = lost_q | lostNow;
  end

  // Next-state logic. Nothing about the grant changes between strobes; at a
  // strobe we either take a counter cycle or release the cycle and clear the
  // run so the sequencer gets at least one full memory cycle.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    gntIdx_d  = gntIdx_q;
    gntPlus_d = gntPlus_q;
    if (bus_io.t12) begin
      if (grantNow) begin
        state_d   = ACTIVE;
        run_d     = run_q + RW'(1);
        gntIdx_d  = selIdx;
        gntPlus_d = pendPlus_q[selIdx];
      end else begin
        state_d   = IDLE;
        run_d     = '0;
        gntIdx_d  = '0;
        gntPlus_d = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clock_i) begin
    if (clearNow) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending, run, grant and lost-flag registers.
  always_ff @(posedge clock_i) begin
    if (clearNow) begin
      pendPlus_q  <= '0;
      pendMinus_q <= '0;
      run_q       <= '0;
      gntIdx_q    <= '0;
      gntPlus_q   <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      pendPlus_q  <= pendPlus_d;
      pendMinus_q <= pendMinus_d;
      run_q       <= run_d;
      gntIdx_q    <= gntIdx_d;
      gntPlus_q   <= gntPlus_d;
      lost_q      <= lost_d;
    end
  end

  // Outputs are decoded from registered state only, so they move on strobe
  // edges (or reset) and are forced to zero whenever the cycle is idle.
  always_comb begin
    bus_io.ctrAct  = 1'b0;
    bus_io.ctrGnt  = '0;
    bus_io.ctrAddr = '0;
    bus_io.ctrPinc = 1'b0;
    bus_io.ctrMinc = 1'b0;
    if (state_q == ACTIVE) begin
      bus_io.ctrAct  = 1'b1;
      bus_io.ctrGnt  = {{(NREQ-1){1'b0}}, 1'b1} << gntIdx_q;
      bus_io.ctrAddr = gntIdx_q;
      bus_io.ctrPinc = gntPlus_q;
      bus_io.ctrMinc = ~gntPlus_q;
    end
  end

  assign bus_io.ctrOr   = |(pendPlus_q | pendMinus_q);
  assign bus_io.ctrLost = lost_q;

endmodule

// File: tb/tb_counter_priority_ctrl.sv
// tb_counter_priority_ctrl
// Purpose: self-checking bench for counter_priority_ctrl. A cell-level model
// tracks pending signs, the current grant, the run length and the lost flag;
// every cycle the DUT outputs are compared against it. Directed scenarios add
// hand-computed literal expectations, then a randomized phase follows.
// Honours CTR_ROUND_ROBIN_EN in the same way as the design.
module tb_counter_priority_ctrl;

  localparam int NREQ   = 8;
  localparam int MAXRUN = 4;

  logic clk;
  logic rst;

  counter_priority_ctrl_if #(.NREQ(NREQ)) bus ();

  counter_priority_ctrl #(
    .NREQ  (NREQ),
    .MAXRUN(MAXRUN)
  ) dut (
    .clock_i (clk),
    .simRst_i(rst),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Reference model state, one entry per cell.
  bit mp[NREQ];
  bit mm[NREQ];
  int mGnt;
  bit mPlus;
  int mRun;
  int mPtr;
  bit mLost;

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep(input logic [NREQ-1:0] pls, input logic [NREQ-1:0] mns,
                           input bit t12, input bit inh, input bit clr);
    int g;
    int start;
    if (clr) begin
      for (int i = 0; i < NREQ; i++) begin
        mp[i] = 0;
        mm[i] = 0;
      end
      mGnt  = -1;
      mPlus = 0;
      mRun  = 0;
      mPtr  = 0;
      mLost = 0;
      return;
    end
    if (t12) begin
      g = -1;
`ifdef CTR_ROUND_ROBIN_EN
      start = mPtr;
`else
      start = 0;
`endif
      if (!inh && mRun < MAXRUN) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (start + k) % NREQ;
          if (g < 0 && (mp[c] || mm[c])) g = c;
        end
      end
      if (g >= 0) begin
        mGnt  = g;
        mPlus = mp[g];
        mRun  = mRun + 1;
        mPtr  = (g + 1) % NREQ;
        mp[g] = 0;
        mm[g] = 0;
      end else begin
        mGnt = -1;
        mRun = 0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if ((pls[i] && mp[i]) || (mns[i] && mm[i])) mLost = 1;
      if (pls[i]) mp[i] = 1;
      if (mns[i]) mm[i] = 1;
      if (mp[i] && mm[i]) begin
        mp[i] = 0;
        mm[i] = 0;
      end
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    bit anyPend;
    bit act;
    act = (mGnt >= 0);
    anyPend = 0;
    for (int i = 0; i < NREQ; i++) if (mp[i] || mm[i]) anyPend = 1;
    checkVal("ctrAct",  int'(bus.ctrAct),  int'(act));
    checkVal("ctrGnt",  int'(bus.ctrGnt),  act ? (1 << mGnt) : 0);
    checkVal("ctrAddr", int'(bus.ctrAddr), act ? mGnt : 0);
    checkVal("ctrPinc", int'(bus.ctrPinc), int'(act && mPlus));
    checkVal("ctrMinc", int'(bus.ctrMinc), int'(act && !mPlus));
    checkVal("ctrOr",   int'(bus.ctrOr),   int'(anyPend));
    checkVal("ctrLost", int'(bus.ctrLost), int'(mLost));
  endtask

  // One clock: drive inputs, step the model on the edge, check 1 ns later.
  task automatic applyStimulus(input logic [NREQ-1:0] pls, input logic [NREQ-1:0] mns,
                               input bit t12, input bit inh, input bit gj, input bit rs);
    bus.pls    = pls;
    bus.mns    = mns;
    bus.t12    = t12;
    bus.inhinc = inh;
    bus.gojam  = gj;
    rst        = rs;
    @(posedge clk);
    modelStep(pls, mns, t12, inh, gj || rs);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 0, 0, 0, 1);
  endtask

  task automatic strobe();
    applyStimulus('0, '0, 1, 0, 0, 0);
  endtask

  task automatic quiet();
    applyStimulus('0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [NREQ-1:0] rp;
    logic [NREQ-1:0] rm;
    compared   = 0;
    mismatched = 0;
    mGnt = -1;
    bus.pls = '0;
    bus.mns = '0;
    bus.t12 = 0;
    bus.inhinc = 0;
    bus.gojam = 0;
    rst = 1;

    // Reset state.
    doReset();
    checkVal("rst_act", int'(bus.ctrAct), 0);
    checkVal("rst_or",  int'(bus.ctrOr), 0);
    checkVal("rst_gnt", int'(bus.ctrGnt), 0);

    // Single plus request on cell 3, granted for one memory cycle.
    applyStimulus(8'h08, '0, 0, 0, 0, 0);
    checkVal("t1_or", int'(bus.ctrOr), 1);
    strobe();
    checkVal("t1_act",  int'(bus.ctrAct), 1);
    checkVal("t1_addr", int'(bus.ctrAddr), 3);
    checkVal("t1_gnt",  int'(bus.ctrGnt), 8);
    checkVal("t1_pinc", int'(bus.ctrPinc), 1);
    quiet();
    checkVal("t1_hold", int'(bus.ctrAddr), 3);
    strobe();
    checkVal("t1_end_act", int'(bus.ctrAct), 0);
    checkVal("t1_end_gnt", int'(bus.ctrGnt), 0);

    // Opposite signs on one cell cancel.
    doReset();
    applyStimulus(8'h20, '0, 0, 0, 0, 0);
    applyStimulus('0, 8'h20, 0, 0, 0, 0);
    checkVal("t2_or", int'(bus.ctrOr), 0);
    strobe();
    checkVal("t2_act", int'(bus.ctrAct), 0);

    // Fixed order 1, 2 (minus), 6.
    doReset();
    applyStimulus(8'h42, 8'h04, 0, 0, 0, 0);
    strobe();
    checkVal("t3_a1", int'(bus.ctrAddr), 1);
    quiet();
    strobe();
    checkVal("t3_a2", int'(bus.ctrAddr), 2);
    checkVal("t3_minc", int'(bus.ctrMinc), 1);
    strobe();
    checkVal("t3_a6", int'(bus.ctrAddr), 6);
    strobe();
    checkVal("t3_idle", int'(bus.ctrAct), 0);

    // Starvation guard: four grants, one idle cycle, then four more.
    doReset();
    applyStimulus(8'hFF, '0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      strobe();
      checkVal("t4_lo", int'(bus.ctrAddr), k);
    end
    strobe();
    checkVal("t4_gap_act", int'(bus.ctrAct), 0);
    checkVal("t4_gap_or",  int'(bus.ctrOr), 1);
    for (int k = 4; k < 8; k++) begin
      strobe();
      checkVal("t4_hi", int'(bus.ctrAddr), k);
    end

    // GOJAM during an active cycle with three cells still pending.
    doReset();
    applyStimulus(8'h0F, '0, 0, 0, 0, 0);
    strobe();
    checkVal("t5_act", int'(bus.ctrAct), 1);
    applyStimulus('0, '0, 0, 0, 1, 0);
    checkVal("t5_gj_act", int'(bus.ctrAct), 0);
    checkVal("t5_gj_or",  int'(bus.ctrOr), 0);
    strobe();
    checkVal("t5_post", int'(bus.ctrAct), 0);

    // Duplicate pulse is lost; then priority among {0,3}.
    doReset();
    applyStimulus(8'h04, '0, 0, 0, 0, 0);
    applyStimulus(8'h04, '0, 0, 0, 0, 0);
    checkVal("t6_lost", int'(bus.ctrLost), 1);
    applyStimulus(8'h09, '0, 1, 0, 0, 0);
    checkVal("t6_g2", int'(bus.ctrAddr), 2);
    strobe();
`ifdef CTR_ROUND_ROBIN_EN
    checkVal("t6_first", int'(bus.ctrAddr), 3);
    strobe();
    checkVal("t6_second", int'(bus.ctrAddr), 0);
`else
    checkVal("t6_first", int'(bus.ctrAddr), 0);
    strobe();
    checkVal("t6_second", int'(bus.ctrAddr), 3);
`endif

    // Inhibit blocks a grant even with requests pending.
    doReset();
    applyStimulus(8'h01, '0, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 1, 0, 0);
    checkVal("inh_act", int'(bus.ctrAct), 0);

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 4000; n++) begin
      rp = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      rm = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      applyStimulus(rp, rm,
                    (n % 2000 < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
